// File: rtl/delay_line_ctrl.sv
// Programmable delay line: a circular sample buffer whose read tap trails the write
// pointer by cur_len enabled cycles, with fill tracking so out_valid marks primed data.
module delay_line_ctrl #(
    parameter int WIDTH       = 8,
    parameter int MAX_LEN     = 16,
    parameter int DEFAULT_LEN = 2,
    parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             ena,
    input  logic [WIDTH-1:0] in,
    input  logic             cfg_load,
    input  logic [LEN_W-1:0] cfg_len,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [LEN_W-1:0] cur_len,
    output logic [LEN_W-1:0] fill_cnt
);

    // state | meaning
    // FILL  | fewer than cur_len samples accepted since the last (re)configuration
    // RUN   | delay line primed (or cur_len == 0 bypass); out carries real samples
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int               PTR_W     = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEFAULT_LEN);
    localparam state_t           RST_STATE = (DEFAULT_LEN == 0) ? RUN : FILL;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [LEN_W-1:0] new_len;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem_q [MAX_LEN];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= RST_STATE;
            wr_ptr_q <= '0;
            len_q    <= DEF_LEN_L;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            len_q    <= len_d;
            fill_q   <= fill_d;
        end
    end

    // Buffer contents are never cleared; fill tracking alone decides validity.
    always_ff @(posedge clk) begin
        if (nrst && ena) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        len_d    = len_q;
        fill_d   = fill_q;
        new_len  = '0;

        if (ena) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (cfg_load) begin
            new_len = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
            len_d   = new_len;
            // A sample accepted on the load cycle already counts toward the new length.
            fill_d  = (ena && (new_len != '0)) ? LEN_W'(1) : '0;
            state_d = (fill_d == new_len) ? RUN : FILL;
        end else if ((state_q == FILL) && ena) begin
            fill_d = fill_q + LEN_W'(1);
            if (fill_d == len_q) begin
                state_d = RUN;
            end
        end
    end

    // MAX_LEN truncates to 0 here, reading the slot about to be overwritten.
    assign rd_ptr = wr_ptr_q - len_q[PTR_W-1:0];

    always_comb begin
        out       = '0;
        out_valid = 1'b0;
        if (len_q == '0) begin
            out       = in;
            out_valid = 1'b1;
        end else if (state_q == RUN) begin
            out       = mem_q[rd_ptr];
            out_valid = 1'b1;
        end
    end

    assign cur_len  = len_q;
    assign fill_cnt = fill_q;

endmodule
